// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hctrl_state_e : sequencer FSM states
//   fwd_sel_e     : EX operand forwarding select encoding
//   REG_X0        : hard-wired zero register address (never forwarded)
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects (pure combinational).
// Ports:
//   ex_rs1 / ex_rs2          : source registers of the EX instruction
//   mem_rd / mem_rd_wren     : MEM-stage destination and write enable
//   wb_rd / wb_rd_wren       : WB-stage destination and write enable
//   fwd_a_sel / fwd_b_sel    : select for operand A / B
// MEM is younger than WB, so it wins when both match.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_rd_wren,
    input  logic [4:0] wb_rd,
    input  logic       wb_rd_wren,
    output fwd_sel_e   fwd_a_sel,
    output fwd_sel_e   fwd_b_sel
);

    function automatic fwd_sel_e pick(input logic [4:0] rs);
        if (rs == REG_X0)                      return FWD_RF;
        else if (mem_rd_wren && mem_rd == rs)  return FWD_MEM;
        else if (wb_rd_wren && wb_rd == rs)    return FWD_WB;
        else                                   return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_sel = pick(ex_rs1);
        fwd_b_sel = pick(ex_rs2);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32 core.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   id_* / ex_* / mem_* / wb_*   : decoded register addresses and control bits
//   mem_req_i / mem_ack_i        : data-memory handshake
//   pipe_valid_i                 : {WB, MEM, EX} valid bits
//   halt_req_i / resume_i        : debug halt (level) and resume (pulse)
//   stall_*_o / flush_*_o        : per-register hold / bubble enables
//   fwd_a_sel_o / fwd_b_sel_o    : EX operand forwarding selects
//   halted_o                     : core halted (registered)
//   stall_cnt_o / flush_cnt_o    : saturating performance counters
// Stall/flush outputs are combinational so a zero-wait ack costs no cycle.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rs1_i,
    input  logic [4:0]       ex_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_rd_wren_i,
    input  logic             ex_is_load_i,
    input  logic             ex_branch_taken_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_rd_wren_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_rd_wren_i,
    input  logic [2:0]       pipe_valid_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             stall_pc_o,
    output logic             stall_if_id_o,
    output logic             stall_id_ex_o,
    output logic             stall_ex_mem_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_mem_wb_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    hctrl_state_e state, state_nxt;
    fwd_sel_e     fwd_a, fwd_b;
    logic         mem_stall, load_use, br_flush;
    logic         st_pc, st_if_id, st_id_ex, st_ex_mem;
    logic         fl_if_id, fl_id_ex, fl_mem_wb;

    fwd_unit u_fwd (
        .ex_rs1      (ex_rs1_i),
        .ex_rs2      (ex_rs2_i),
        .mem_rd      (mem_rd_i),
        .mem_rd_wren (mem_rd_wren_i),
        .wb_rd       (wb_rd_i),
        .wb_rd_wren  (wb_rd_wren_i),
        .fwd_a_sel   (fwd_a),
        .fwd_b_sel   (fwd_b)
    );

    assign mem_stall = mem_req_i && !mem_ack_i;
    assign load_use  = ex_is_load_i && ex_rd_wren_i && (ex_rd_i != REG_X0) &&
                       ((id_rs1_used_i && id_rs1_i == ex_rd_i) ||
                        (id_rs2_used_i && id_rs2_i == ex_rd_i));

    always_comb begin
        state_nxt = state;
        st_pc     = 1'b0;
        st_if_id  = 1'b0;
        st_id_ex  = 1'b0;
        st_ex_mem = 1'b0;
        fl_if_id  = 1'b0;
        fl_id_ex  = 1'b0;
        fl_mem_wb = 1'b0;
        br_flush  = 1'b0;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    // Freeze IF..MEM and bubble WB; EX is frozen so branch
                    // and load-use are re-evaluated after the release.
                    {st_pc, st_if_id, st_id_ex, st_ex_mem} = 4'b1111;
                    fl_mem_wb = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end else begin
                    state_nxt = ST_RUN;
                    if (ex_branch_taken_i) begin
                        fl_if_id = 1'b1;
                        fl_id_ex = 1'b1;
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        st_pc    = 1'b1;
                        st_if_id = 1'b1;
                        fl_id_ex = 1'b1;
                    end else if (state == ST_RUN && halt_req_i) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            default: begin // ST_DRAIN, ST_HALTED
                if (mem_stall) begin
                    {st_pc, st_if_id, st_id_ex, st_ex_mem} = 4'b1111;
                    fl_mem_wb = 1'b1;
                end else begin
                    // Hold the ID instruction, let EX/MEM/WB empty out.
                    st_if_id = 1'b1;
                    fl_id_ex = 1'b1;
                    if (ex_branch_taken_i) begin
                        // Let the redirect land in PC; the fetched slot is dropped.
                        fl_if_id = 1'b1;
                        br_flush = 1'b1;
                    end else begin
                        st_pc = 1'b1;
                    end
                end
                if (state == ST_DRAIN) begin
                    if (pipe_valid_i == 3'b000 && !mem_stall) state_nxt = ST_HALTED;
                    else if (!halt_req_i)                    state_nxt = ST_RUN;
                end else if (resume_i) begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            halted_o    <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            halted_o <= (state_nxt == ST_HALTED);
            if (st_pc && state != ST_HALTED && stall_cnt_o != {CNT_W{1'b1}})
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (br_flush && flush_cnt_o != {CNT_W{1'b1}})
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

    // Reset forces every control output quiet, independent of the inputs.
    assign stall_pc_o     = !rst_i && st_pc;
    assign stall_if_id_o  = !rst_i && st_if_id;
    assign stall_id_ex_o  = !rst_i && st_id_ex;
    assign stall_ex_mem_o = !rst_i && st_ex_mem;
    assign flush_if_id_o  = !rst_i && fl_if_id;
    assign flush_id_ex_o  = !rst_i && fl_id_ex;
    assign flush_mem_wb_o = !rst_i && fl_mem_wb;
    assign fwd_a_sel_o    = rst_i ? FWD_RF : fwd_a;
    assign fwd_b_sel_o    = rst_i ? FWD_RF : fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each vector drives inputs after a rising
// edge and queues its hand-computed expected outputs; a monitor on the
// falling edge pops and compares. Control bits are packed as
// {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}.
module tb_hazard_ctrl;

    localparam logic [6:0] NONE  = 7'b0000_000;
    localparam logic [6:0] FRZ   = 7'b1111_001; // memory wait freeze
    localparam logic [6:0] BR    = 7'b0000_110; // branch flush
    localparam logic [6:0] LU    = 7'b1100_010; // load-use bubble
    localparam logic [6:0] DR    = 7'b1100_010; // drain / halted hold
    localparam logic [6:0] DR_BR = 7'b0100_110; // drain with redirect

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_rs1_used, id_rs2_used, ex_rd_wren, ex_is_load, ex_branch_taken;
    logic mem_rd_wren, mem_req, mem_ack, wb_rd_wren, halt_req, resume;
    logic [2:0] pipe_valid;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_mem_wb, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
        .ex_rd_wren_i(ex_rd_wren), .ex_is_load_i(ex_is_load),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_rd_i(mem_rd), .mem_rd_wren_i(mem_rd_wren),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .wb_rd_i(wb_rd), .wb_rd_wren_i(wb_rd_wren),
        .pipe_valid_i(pipe_valid), .halt_req_i(halt_req), .resume_i(resume),
        .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id),
        .stall_id_ex_o(stall_id_ex), .stall_ex_mem_o(stall_ex_mem),
        .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
        .flush_mem_wb_o(flush_mem_wb),
        .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .halted_o(halted),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    typedef struct {
        int         id;
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       h;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vid    = 0;
    int   errors = 0;
    int   checks = 0;

    // Monitor: pops one expectation per falling edge when one is pending.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            logic [6:0] ctl;
            e   = q.pop_front();
            ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                   flush_if_id, flush_id_ex, flush_mem_wb};
            checks++;
            if (ctl !== e.ctl || fwd_a !== e.fa || fwd_b !== e.fb || halted !== e.h) begin
                errors++;
                $display("FAIL vec%0d ctrl: got ctl=%b fa=%b fb=%b halted=%b, want ctl=%b fa=%b fb=%b halted=%b",
                         e.id, ctl, fwd_a, fwd_b, halted, e.ctl, e.fa, e.fb, e.h);
            end
            checks++;
            if (stall_cnt !== 32'(e.sc) || flush_cnt !== 32'(e.fc)) begin
                errors++;
                $display("FAIL vec%0d counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                         e.id, stall_cnt, flush_cnt, e.sc, e.fc);
            end
        end
    end

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_rd_wren, ex_is_load, ex_branch_taken} = '0;
        {mem_rd_wren, mem_req, mem_ack, wb_rd_wren, halt_req, resume} = '0;
        pipe_valid = 3'b000;
    endtask

    // Queue expectation for the inputs just driven, then advance one cycle.
    task automatic chk(input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic h, input int sc, input int fc);
        exp_t x;
        x.id = vid; x.ctl = ctl; x.fa = fa; x.fb = fb; x.h = h; x.sc = sc; x.fc = fc;
        q.push_back(x);
        vid++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        // V0: reset held with busy inputs -> everything quiet
        mem_req = 1; ex_branch_taken = 1; mem_rd = 5; mem_rd_wren = 1; ex_rs1 = 5;
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        rst = 0; idle();
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        // Forwarding: MEM priority, x0 never forwarded
        mem_rd = 5; mem_rd_wren = 1; wb_rd = 5; wb_rd_wren = 1; ex_rs1 = 5; ex_rs2 = 0;
        chk(NONE, 2'b01, 2'b00, 0, 0, 0);
        idle(); mem_rd = 5; wb_rd = 6; wb_rd_wren = 1; ex_rs1 = 6; ex_rs2 = 5;
        chk(NONE, 2'b10, 2'b00, 0, 0, 0);
        idle(); mem_rd_wren = 1; wb_rd_wren = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        // Load-use on rs2, then release
        idle(); ex_is_load = 1; ex_rd_wren = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
        chk(LU, 2'b00, 2'b00, 0, 0, 0);
        idle();
        chk(NONE, 2'b00, 2'b00, 0, 1, 0);
        // Matching registers that are not read, and a load to x0
        ex_is_load = 1; ex_rd_wren = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 7;
        chk(NONE, 2'b00, 2'b00, 0, 1, 0);
        idle(); ex_is_load = 1; ex_rd_wren = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        chk(NONE, 2'b00, 2'b00, 0, 1, 0);
        // 3-cycle memory wait under a taken branch, branch flush on ack
        idle(); mem_req = 1; ex_branch_taken = 1;
        chk(FRZ, 2'b00, 2'b00, 0, 1, 0);
        chk(FRZ, 2'b00, 2'b00, 0, 2, 0);
        chk(FRZ, 2'b00, 2'b00, 0, 3, 0);
        mem_ack = 1;
        chk(BR, 2'b00, 2'b00, 0, 4, 0);
        idle();
        chk(NONE, 2'b00, 2'b00, 0, 4, 1);
        // Zero-wait access: no stall
        mem_req = 1; mem_ack = 1;
        chk(NONE, 2'b00, 2'b00, 0, 4, 1);
        idle();
        chk(NONE, 2'b00, 2'b00, 0, 4, 1);
        // Halt: drain 111 -> 011 -> 001 -> 000, halted, resume
        halt_req = 1; pipe_valid = 3'b111;
        chk(NONE, 2'b00, 2'b00, 0, 4, 1);
        pipe_valid = 3'b011;
        chk(DR, 2'b00, 2'b00, 0, 4, 1);
        pipe_valid = 3'b001;
        chk(DR, 2'b00, 2'b00, 0, 5, 1);
        pipe_valid = 3'b000;
        chk(DR, 2'b00, 2'b00, 0, 6, 1);
        chk(DR, 2'b00, 2'b00, 1, 7, 1);
        chk(DR, 2'b00, 2'b00, 1, 7, 1);
        halt_req = 0; resume = 1;
        chk(DR, 2'b00, 2'b00, 1, 7, 1);
        resume = 0;
        chk(NONE, 2'b00, 2'b00, 0, 7, 1);
        // Halt again, redirect during drain, then abandon the halt
        halt_req = 1; pipe_valid = 3'b111;
        chk(NONE, 2'b00, 2'b00, 0, 7, 1);
        pipe_valid = 3'b011; ex_branch_taken = 1;
        chk(DR_BR, 2'b00, 2'b00, 0, 7, 1);
        ex_branch_taken = 0; halt_req = 0;
        chk(DR, 2'b00, 2'b00, 0, 7, 2);
        idle();
        chk(NONE, 2'b00, 2'b00, 0, 8, 2);
        // Reset in the middle of a memory wait
        mem_req = 1;
        chk(FRZ, 2'b00, 2'b00, 0, 8, 2);
        chk(FRZ, 2'b00, 2'b00, 0, 9, 2);
        rst = 1;
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        rst = 0; idle();
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        // Back in RUN: halt request produces no outputs in its first cycle
        halt_req = 1; pipe_valid = 3'b111;
        chk(NONE, 2'b00, 2'b00, 0, 0, 0);
        halt_req = 0;
        chk(DR, 2'b00, 2'b00, 0, 0, 0);
        idle();
        chk(NONE, 2'b00, 2'b00, 0, 1, 0);
        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
